fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that owns the architectural program counter. It registers the next-PC value from the PC-select logic, issues one read per instruction to instruction memory over a request/response handshake, and holds the fetched word for decode under a valid/ready handshake. The block sits directly downstream of next-PC selection: its `pc` output feeds that logic, and its `pc_next` input comes back from it.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `pc_next`  in  32: next PC from PC-select logic; sampled only on an instruction handoff.
- `pc`  out  32: PC of the instruction currently being fetched or held.
- `imem_req`  out  1: read request, one-cycle pulse.
- `imem_addr`  out  32: word-aligned read address.
- `imem_rvalid`  in  1: read data valid.
- `imem_rdata`  in  32: read data.
- `instr`  out  32: fetched instruction word (registered).
- `instr_valid`  out  1: `instr` and `pc` are valid for decode.
- `instr_ready`  in  1: decode accepts the held instruction.
- `fetch_count`  out  32: number of completed fetches.
- `fetch_fault`  out  1: sticky misaligned-PC fault. Tied to 0 when the configuration macro is absent.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and HOLD, plus FAULT when the macro is defined.
- IDLE: entered on reset; moves to REQ unconditionally on the next edge.
- REQ: `imem_req`=1, `imem_addr`={pc[31:2],2'b00}; moves to WAIT.
- WAIT: `imem_req`=0.
  - On `imem_rvalid`=1: `instr`<=`imem_rdata`, `fetch_count`<=`fetch_count`+1 (wraps 2^32-1 -> 0), move to HOLD.
  - Otherwise stay; there is no timeout.
- HOLD: `instr_valid`=1; `instr` and `pc` are stable.
  - On `instr_ready`=1: `pc`<=`pc_next`, move to REQ.
  - Otherwise stay. `pc_next` changes are ignored.
- `imem_rvalid` outside WAIT is ignored; no register changes.
- `instr_ready` outside HOLD is ignored.
- `instr_valid` is combinational from state (HOLD only). `imem_req` is combinational from state (REQ only).
- Only one request is outstanding at a time. The memory must return exactly one `imem_rvalid` per request.

## Timing
- Reset values: `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`={RESET_PC[31:2],2'b00}, `fetch_count`=0, `fetch_fault`=0, state IDLE.
- First `imem_req` appears in the second cycle after `rst_n` deasserts (IDLE, then REQ).
- Earliest `imem_rvalid` is sampled in the cycle after REQ.
- Minimum throughput is 3 cycles per instruction: REQ, WAIT with rvalid, HOLD with ready.
- Zero-wait memory plus always-ready decode gives `instr_valid` high 1 cycle in 3.
- Reset mid-operation: all state clears asynchronously, including in WAIT. A late `imem_rvalid` after reset is ignored because state is not WAIT.
- Same-cycle handoff in HOLD: the new `pc` is visible on `imem_addr` in the next cycle (REQ).

## Configuration
- `FETCH_ALIGN_CHECK_EN`
  - Defined: on a HOLD handoff with `pc_next[1:0]`≠0, `pc` still loads `pc_next`, but the FSM enters FAULT instead of REQ.
  - In FAULT: `fetch_fault`=1, `imem_req`=0, `instr_valid`=0. FAULT is left only by reset.
  - Undefined: there is no FAULT state, `fetch_fault`=0, and the low PC bits are dropped on `imem_addr` only (`pc` keeps them).

## Test plan
- Reset then release, RESET_PC=32'h100, memory returns 32'h0000_0013 one cycle after req, `instr_ready`=1, `pc_next`=`pc`+4 -> requests at 0x100, 0x104, 0x108 every 3 cycles; `instr`=32'h13; `fetch_count` increments per fetch.
- Memory latency 5 cycles -> FSM stays in WAIT 5 cycles, `imem_req` pulses exactly once per fetch, `instr_valid` low throughout the wait.
- `instr_ready`=0 for 4 cycles in HOLD while `pc_next` toggles 0x200/0x300 -> `instr`/`pc` stable; on ready, `pc` takes the value present that cycle.
- Spurious `imem_rvalid` with rdata 32'hDEAD_BEEF in REQ or HOLD -> `instr` unchanged, `fetch_count` unchanged.
- Assert `rst_n`=0 mid-WAIT, then return rvalid after release -> outputs at reset values, rvalid ignored, new fetch starts at RESET_PC.
- With `FETCH_ALIGN_CHECK_EN`: handoff with `pc_next`=32'h202 -> `fetch_fault`=1 next cycle, no further `imem_req` until reset. Without the macro: `imem_addr`=32'h200, `fetch_fault`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem read per instruction, holds the word for decode.
// Latency: first imem_req 2 cycles after reset release; 3 cycles per instruction minimum (REQ, WAIT, HOLD).
// Backpressure: stalls in HOLD until instr_ready, in WAIT until imem_rvalid. Option: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic handoff;
  logic fetch_done;

  assign handoff    = (state == HOLD) && instr_ready;
  assign fetch_done = (state == WAIT) && imem_rvalid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      WAIT: if (imem_rvalid) state_nxt = HOLD;
      HOLD: begin
        if (instr_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
          // Misaligned target is still loaded into pc so the faulting address is visible.
          if (pc_next[1:0] != 2'b00) state_nxt = FAULT;
          else                       state_nxt = REQ;
`else
          state_nxt = REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: state_nxt = FAULT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state <= state_nxt;
      if (handoff) pc <= pc_next;
      if (fetch_done) begin
        instr       <= imem_rdata;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  assign imem_req    = (state == REQ);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = {pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = (state == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
